// File: rtl/game_pkg.sv
// game_pkg: round FSM state encoding and default difficulty/score constants
// shared by the round scheduler blocks.
package game_pkg;
    typedef enum logic [2:0] {IDLE, REQUEST, WAIT, JUDGE, PENALTY, OVER} round_state_t;
    localparam int unsigned BASE_RATE = 36000000;
    localparam int unsigned RATE_STEP = 4000000;
    localparam int unsigned MAX_LEVEL = 7;
    localparam int unsigned SCORE_MAX = 999;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus symmetric debounce counter for an
// active-low button; press_evt_o pulses once per accepted press.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
    input  logic clk_12MHz,
    input  logic reset,
    input  logic btn_n_i,
    output logic press_evt_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync_q;
    logic          pressed_q, pressed_d, evt_q, evt_d, raw_pressed;
    logic [CW-1:0] cnt_q, cnt_d;

    assign raw_pressed = !sync_q[1];
    assign press_evt_o = evt_q;

    // The counter only runs while the synced level disagrees with the accepted one.
    always_comb begin
        pressed_d = pressed_q;
        evt_d     = 1'b0;
        cnt_d     = '0;
        if (raw_pressed != pressed_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                pressed_d = raw_pressed;
                evt_d     = raw_pressed;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_12MHz) begin
        if (!reset) begin
            sync_q    <= 2'b11;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
            evt_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_n_i};
            pressed_q <= pressed_d;
            cnt_q     <= cnt_d;
            evt_q     <= evt_d;
        end
    end
endmodule

// File: rtl/round_scheduler.sv
// round_scheduler: submit/judge/penalty game-flow FSM with operand handshake and
// level-based deduct rate. Wrong-answer lockout is built only with ROUND_SCHED_PENALTY_EN.
module round_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned PER_LEVEL       = 5,
    parameter int unsigned MAX_LEVEL       = game_pkg::MAX_LEVEL,
    parameter int unsigned BASE_RATE       = game_pkg::BASE_RATE,
    parameter int unsigned RATE_STEP       = game_pkg::RATE_STEP
`ifdef ROUND_SCHED_PENALTY_EN
    , parameter int unsigned PENALTY_CYCLES = 12000000
`endif
) (
    input  logic        clk_12MHz,
    input  logic        reset,
    input  logic        check_answer_i,
    input  logic        answer_correct_i,
    input  logic        health_zero_i,
    input  logic        gen_ack_i,
    output logic        gen_req_o,
    output logic        submit_ok_o,
    output logic        submit_bad_o,
    output logic        locked_o,
    output logic [2:0]  level_o,
    output logic [9:0]  score_o,
    output logic [26:0] deduct_rate_o,
    output logic        game_over_o
);
    import game_pkg::*;
    localparam int PW = $clog2(PER_LEVEL + 1);

    round_state_t  state_q, state_d;
    logic          press_evt, good;
    logic [PW-1:0] per_q, per_d, per_inc;
    logic [2:0]    level_q, level_d;
    logic [9:0]    score_q, score_d;
    logic [26:0]   rate_q, rate_d;
    logic          gen_req_q, ok_q, over_q, lvl_up;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk_12MHz   (clk_12MHz),
        .reset       (reset),
        .btn_n_i     (check_answer_i),
        .press_evt_o (press_evt)
    );

    assign good    = state_q == JUDGE && answer_correct_i && !health_zero_i;
    assign per_inc = per_q + 1'b1;
    assign lvl_up  = good && per_inc == PW'(PER_LEVEL);
    assign per_d   = good ? (lvl_up ? '0 : per_inc) : per_q;
    assign level_d = lvl_up && level_q != 3'(MAX_LEVEL) ? level_q + 3'd1 : level_q;
    assign score_d = good && score_q != 10'(SCORE_MAX) ? score_q + 10'd1 : score_q;
    assign rate_d  = 27'(BASE_RATE - RATE_STEP * 32'(level_d));

`ifdef ROUND_SCHED_PENALTY_EN
    localparam int PCW = $clog2(PENALTY_CYCLES + 1);
    logic [PCW-1:0] pen_q;
    logic           bad_q, locked_q;
    assign submit_bad_o = bad_q;
    assign locked_o     = locked_q;
    always_ff @(posedge clk_12MHz) begin
        if (!reset) begin
            pen_q    <= '0;
            bad_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            pen_q    <= state_q == PENALTY ? pen_q + 1'b1 : '0;
            bad_q    <= state_q == JUDGE && !answer_correct_i && !health_zero_i;
            locked_q <= state_d == PENALTY;
        end
    end
`else
    assign submit_bad_o = 1'b0;
    assign locked_o     = 1'b0;
`endif

    // health_zero overrides every transition, OVER is only left through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = REQUEST;
            REQUEST: state_d = gen_ack_i ? WAIT : REQUEST;
            WAIT:    state_d = press_evt ? JUDGE : WAIT;
`ifdef ROUND_SCHED_PENALTY_EN
            JUDGE:   state_d = answer_correct_i ? REQUEST : PENALTY;
            PENALTY: state_d = pen_q == PCW'(PENALTY_CYCLES - 1) ? WAIT : PENALTY;
`else
            JUDGE:   state_d = answer_correct_i ? REQUEST : WAIT;
`endif
            default: state_d = state_q;
        endcase
        if (health_zero_i) state_d = OVER;
    end

    always_ff @(posedge clk_12MHz) begin
        if (!reset) begin
            state_q   <= IDLE;
            per_q     <= '0;
            level_q   <= '0;
            score_q   <= '0;
            rate_q    <= 27'(BASE_RATE);
            gen_req_q <= 1'b0;
            ok_q      <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            level_q   <= level_d;
            score_q   <= score_d;
            rate_q    <= rate_d;
            gen_req_q <= state_d == REQUEST;
            ok_q      <= good;
            over_q    <= state_d == OVER;
        end
    end

    assign gen_req_o     = gen_req_q;
    assign submit_ok_o   = ok_q;
    assign level_o       = level_q;
    assign score_o       = score_q;
    assign deduct_rate_o = rate_q;
    assign game_over_o   = over_q;
endmodule

// File: tb/tb_round_scheduler.sv
// tb_round_scheduler: directed table-driven bench for round_scheduler with
// shortened debounce/penalty times; follows ROUND_SCHED_PENALTY_EN if defined.
module tb_round_scheduler;
    localparam int DEB = 20;
    localparam int PEN = 100;
`ifdef ROUND_SCHED_PENALTY_EN
    localparam int PEN_ON = 1;
`else
    localparam int PEN_ON = 0;
`endif

    logic        clk = 0, rst = 0, btn = 1, answer_correct = 0, hz = 0, gen_ack = 0;
    logic        gen_req, submit_ok, submit_bad, locked, game_over;
    logic [2:0]  level;
    logic [9:0]  score;
    logic [26:0] deduct_rate;
    int checks = 0, errors = 0;

    typedef struct {
        bit c;
        int ok;
        int bad;
        int score;
        int level;
        int rate;
    } vec_t;
    vec_t tbl[7];

    always #5 clk = ~clk;

    round_scheduler #(
        .DEBOUNCE_CYCLES(DEB)
`ifdef ROUND_SCHED_PENALTY_EN
        , .PENALTY_CYCLES(PEN)
`endif
    ) dut (
        .clk_12MHz        (clk),
        .reset            (rst),
        .check_answer_i   (btn),
        .answer_correct_i (answer_correct),
        .health_zero_i    (hz),
        .gen_ack_i        (gen_ack),
        .gen_req_o        (gen_req),
        .submit_ok_o      (submit_ok),
        .submit_bad_o     (submit_bad),
        .locked_o         (locked),
        .level_o          (level),
        .score_o          (score),
        .deduct_rate_o    (deduct_rate),
        .game_over_o      (game_over)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic handshake();
        for (int i = 0; i < 20 && !gen_req; i++) @(negedge clk);
        chk("req_seen", gen_req, 1);
        gen_ack = 1;
        @(negedge clk);
        gen_ack = 0;
        chk("req_drop", gen_req, 0);
    endtask

    task automatic press(input bit c, output int n_ok, output int n_bad,
                         output logic [2:0] lv, output logic [26:0] rt);
        n_ok = 0; n_bad = 0; lv = level; rt = deduct_rate;
        answer_correct = c;
        btn = 0;
        for (int i = 0; i < 2 * DEB + 15; i++) begin
            if (i == DEB + 10) btn = 1;
            @(negedge clk);
            if (submit_ok) begin n_ok++; lv = level; rt = deduct_rate; end
            if (submit_bad) n_bad++;
        end
        for (int i = 0; i < 3 * PEN && locked; i++) @(negedge clk);
        if (n_ok > 0) handshake();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n, nb, lock_n;
        logic [2:0] lv;
        logic [26:0] rt;
        bit seen;
        tbl[0] = '{1, 1, 0, 1, 0, 36000000};
        tbl[1] = '{1, 1, 0, 2, 0, 36000000};
        tbl[2] = '{1, 1, 0, 3, 0, 36000000};
        tbl[3] = '{1, 1, 0, 4, 0, 36000000};
        tbl[4] = '{1, 1, 0, 5, 1, 32000000};
        tbl[5] = '{0, 0, PEN_ON, 5, 1, 32000000};
        tbl[6] = '{1, 1, 0, 6, 1, 32000000};

        cyc(3);
        chk("rst_gen_req", gen_req, 0);
        chk("rst_ok", submit_ok, 0);
        chk("rst_bad", submit_bad, 0);
        chk("rst_locked", locked, 0);
        chk("rst_level", level, 0);
        chk("rst_score", score, 0);
        chk("rst_rate", deduct_rate, 36000000);
        chk("rst_over", game_over, 0);

        rst = 1;
        #1 chk("req_cycle1", gen_req, 0);
        @(negedge clk);
        chk("req_cycle2", gen_req, 1);
        cyc(2);
        chk("req_held", gen_req, 1);
        gen_ack = 1;
        @(negedge clk);
        gen_ack = 0;
        chk("req_after_ack", gen_req, 0);

        // bounce shorter than the debounce window, then a real hold
        answer_correct = 1; n = 0;
        for (int i = 0; i < 100; i++) begin
            btn = ((i / 10) % 2) == 1;
            @(negedge clk);
            n += int'(submit_ok);
        end
        chk("bounce_quiet", n, 0);
        btn = 0; n = 0;
        repeat (DEB + 10) begin @(negedge clk); n += int'(submit_ok); end
        chk("bounce_one", n, 1);
        handshake();
        n = 0;
        repeat (3 * DEB) begin @(negedge clk); n += int'(submit_ok); end
        chk("hold_no_second", n, 0);
        btn = 1;
        cyc(DEB + 5);
        chk("bounce_score", score, 1);

        // reset while gen_req is pending
        btn = 0; n = 0;
        repeat (DEB + 10) begin @(negedge clk); n += int'(submit_ok); end
        chk("pre_rst_ok", n, 1);
        chk("pre_rst_req", gen_req, 1);
        chk("pre_rst_score", score, 2);
        rst = 0;
        @(negedge clk);
        chk("mid_rst_req", gen_req, 0);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_level", level, 0);
        btn = 1;
        cyc(DEB + 5);
        rst = 1;
        handshake();

        for (int v = 0; v < 7; v++) begin
            press(tbl[v].c, n, nb, lv, rt);
            chk($sformatf("v%0d_ok", v), n, tbl[v].ok);
            chk($sformatf("v%0d_bad", v), nb, tbl[v].bad);
            chk($sformatf("v%0d_score", v), score, tbl[v].score);
            chk($sformatf("v%0d_level", v), lv, tbl[v].level);
            chk($sformatf("v%0d_rate", v), rt, tbl[v].rate);
        end

        for (int v = 0; v < 29; v++) press(1, n, nb, lv, rt);
        chk("sat_score", score, 35);
        chk("sat_level", level, 7);
        chk("sat_rate", deduct_rate, 8000000);

`ifdef ROUND_SCHED_PENALTY_EN
        answer_correct = 0; btn = 0; seen = 0;
        for (int i = 0; i < DEB + 10 && !seen; i++) begin @(negedge clk); seen = submit_bad; end
        chk("pen_bad_pulse", seen, 1);
        chk("pen_locked_start", locked, 1);
        answer_correct = 1; lock_n = 1; n = 0;
        for (int i = 0; i < 3 * PEN; i++) begin
            btn = (i < DEB + 5 || i >= 2 * DEB + 10);
            @(negedge clk);
            lock_n += int'(locked);
            n += int'(submit_ok);
        end
        chk("pen_lock_len", lock_n, PEN);
        chk("pen_press_ignored", n, 0);
`else
        answer_correct = 0; btn = 0; n = 0; nb = 0;
        repeat (DEB + 10) begin @(negedge clk); n += int'(submit_ok); nb += int'(submit_bad | locked); end
        chk("nopen_no_ok", n, 0);
        chk("nopen_no_bad", nb, 0);
        btn = 1;
        cyc(DEB + 5);
`endif
        press(1, n, nb, lv, rt);
        chk("after_wrong_ok", n, 1);
        chk("after_wrong_score", score, 36);
        chk("after_wrong_level", level, 7);

        // health_zero in the same cycle as the press event
        answer_correct = 1; btn = 0; seen = 0;
        for (int i = 0; i < DEB + 10 && !seen; i++) begin @(negedge clk); seen = dut.u_deb.press_evt_o; end
        hz = 1;
        chk("hz_evt_seen", seen, 1);
        @(negedge clk);
        chk("hz_over_next", game_over, 1);
        chk("hz_req_low", gen_req, 0);
        n = int'(submit_ok);
        hz = 0;
        repeat (10) begin @(negedge clk); n += int'(submit_ok); end
        chk("hz_no_ok", n, 0);
        chk("hz_over_sticky", game_over, 1);
        chk("hz_score_kept", score, 36);
        btn = 1;
        rst = 0;
        @(negedge clk);
        chk("hz_over_cleared", game_over, 0);
        rst = 1;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
